// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC holder and IF/ID register for a single-issue MIPS core.
// Drives the word address to a combinational instruction memory, registers the
// returned instruction with a valid/ready handshake toward decode, and accepts
// redirects from execute that kill the in-flight IF/ID entry.
// Optional build macro: JUMP_PREDECODE_EN resolves j/jal at fetch time so they
// cost no bubbles; without it j/jal are resolved by execute through a redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_instr,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             id_ready,
  output logic             if_valid,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_pc_plus4,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_count
);

  logic [31:0]      pc_q, pc_d;
  logic             if_valid_q, if_valid_d;
  logic [31:0]      if_instr_q, if_instr_d;
  logic [31:0]      if_pc_q, if_pc_d;
  logic [31:0]      if_pc_plus4_q, if_pc_plus4_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

  logic        load;
  logic        consume;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  // Sequential successor of the PC; wraps naturally at 2^32.
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    next_pc  = pc_plus4;
`ifdef JUMP_PREDECODE_EN
    // j (000010) / jal (000011): take the pseudo-direct target straight away.
    if (imem_instr[31:27] == 5'b00001)
      next_pc = {pc_plus4[31:28], imem_instr[25:0], 2'b00};
`endif
  end

  // Next-state for PC and IF/ID: redirect beats load, otherwise stall holds.
  always_comb begin
    load          = !if_valid_q || id_ready;
    consume       = if_valid_q && id_ready && !redirect_valid;
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;
    misalign_d    = misalign_q;
    fetch_count_d = consume ? fetch_count_q + CNT_W'(1) : fetch_count_q;
    if (redirect_valid) begin
      // Low address bits are dropped; a non-zero pair is latched as an error.
      pc_d       = {redirect_pc[31:2], 2'b00};
      if_valid_d = 1'b0;
      misalign_d = misalign_q | (|redirect_pc[1:0]);
    end else if (load) begin
      if_instr_d    = imem_instr;
      if_pc_d       = pc_q;
      if_pc_plus4_d = pc_plus4;
      if_valid_d    = 1'b1;
      pc_d          = next_pc;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      if_pc_plus4_q <= '0;
      misalign_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Memory address comes only from the PC flop, never from an input.
  assign imem_addr    = pc_q;
  assign if_valid     = if_valid_q;
  assign if_instr     = if_instr_q;
  assign if_pc        = if_pc_q;
  assign if_pc_plus4  = if_pc_plus4_q;
  assign misalign_err = misalign_q;
  assign fetch_count  = fetch_count_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch-side initiator for the combinational instruction memory of the single-issue MIPS core. Holds the PC and drives the word address to instruction memory. Captures the returned instruction into a registered IF/ID stage with a valid/ready handshake toward decode. Accepts branch/jump/jr redirects from execute and kills the in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
CNT_W, 32, width of the delivered-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
imem_addr  output  32  byte address to instruction memory; equals PC register
imem_instr  input  32  instruction word returned combinationally for imem_addr
redirect_valid  input  1  execute requests PC change (taken beq, j, jal, jr)
redirect_pc  input  32  target byte address for the redirect
id_ready  input  1  decode can accept if_instr this cycle
if_valid  output  1  if_instr/if_pc/if_pc_plus4 hold a valid instruction
if_instr  output  32  fetched instruction
if_pc  output  32  address the instruction was fetched from
if_pc_plus4  output  32  if_pc + 4, used for jal link and branch base
misalign_err  output  1  sticky; set when redirect_pc[1:0] != 0
fetch_count  output  CNT_W  count of instructions accepted by decode

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). On a clk edge with rst=1: pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, misalign_err=0, fetch_count=0. rst has priority over all other inputs; an asserted rst mid-stream discards the IF/ID contents.
- imem_addr = pc at all times, with no combinational path from any input.
- Output register "load" condition: load = !if_valid || id_ready.
- Priority per edge, with rst deasserted:
  1. redirect_valid=1: pc = {redirect_pc[31:2],2'b00}; if_valid=0, which kills the current IF/ID entry even if id_ready=1. The entry is not counted. misalign_err |= (redirect_pc[1:0]!=0).
  2. Else if load: if_instr=imem_instr; if_pc=pc; if_pc_plus4=pc+4; if_valid=1; pc=next_pc.
  3. Else (stall): pc and all IF/ID outputs hold.
- next_pc = pc+4, computed modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Handshake: decode consumes the entry on an edge where if_valid && id_ready. fetch_count increments by 1 on that edge unless redirect_valid=1, and wraps at 2^CNT_W. if_* outputs must not change while if_valid && !id_ready, except on redirect or reset.
- Latency: an instruction at address A appears on if_instr the cycle after imem_addr=A and load=1. Sustained throughput is 1 instruction/cycle with id_ready=1. A redirect costs exactly 1 bubble cycle.
- An all-zero imem_instr (unmapped address) is delivered as a normal instruction (nop); no special handling.

Optional Feature:
JUMP_PREDECODE_EN
- Defined: on a load where imem_instr[31:26] is 6'b000010 (j) or 6'b000011 (jal), next_pc = {pc_plus4[31:28], imem_instr[25:0], 2'b00} instead of pc+4. The jump instruction is still delivered to decode with if_pc_plus4 = pc+4 for the link value. Execute does not redirect for j/jal, so these jumps cost 0 bubbles. redirect_valid keeps priority on the same edge.
- Undefined: no predecode; j/jal follow the sequential path and are resolved by redirect_valid (1 bubble).

Test Plan:
- Reset: rst=1 for 2 cycles, then release -> imem_addr=0, if_valid=0 during reset; 1st edge after release gives if_pc=0, if_valid=1, imem_addr=4; fetch_count=0.
- Streaming: id_ready=1 for 4 cycles -> if_pc sequence 0,4,8,12; if_pc_plus4 = if_pc+4; fetch_count=3 after the 4th edge (first edge only loads).
- Stall: if_pc=8 valid, id_ready=0 for 3 cycles -> if_instr, if_pc=8 and imem_addr=12 stable, fetch_count unchanged; id_ready=1 -> if_pc=12 next.
- Redirect while stalled: if_valid=1, id_ready=0, redirect_valid=1, redirect_pc=32'h34 -> next edge if_valid=0, imem_addr=32'h34, fetch_count unchanged; following edge if_pc=32'h34.
- Misaligned and wrap: redirect_pc=32'h36 -> imem_addr=32'h34, misalign_err=1 until rst. Redirect to 32'hFFFF_FFFC, then one load -> imem_addr=0.
- jal predecode: imem_instr at 0x24 = 32'h0C00000D. With JUMP_PREDECODE_EN -> imem_addr=32'h34 after load, if_pc_plus4=32'h28. Without -> imem_addr=32'h28.
